// File: rtl/axil_regfile.sv
// axil_regfile: AXI4-Lite slave over a byte-strobed register array with per-register commit pulses.
// Define AXIL_REGFILE_ADDR_CHECK_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module axil_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    AWVALID,
    output logic                    AwREADY,
    input  logic [ADDR_W-1:0]       AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_W-1:0]       WDATA,
    input  logic [DATA_W/8-1:0]     WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_W-1:0]       ARADDR,
    input  logic [2:0]              ARPROT,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_W-1:0]       RDATA,
    output logic [1:0]              RRESP,
    output logic [DEPTH*DATA_W-1:0] reg_out,
    output logic [DEPTH-1:0]        wr_pulse
);
    localparam int SW  = DATA_W / 8;
    localparam int OFS = $clog2(SW);
    localparam int IW  = $clog2(DEPTH);
`ifdef AXIL_REGFILE_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    function automatic logic [IW-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[OFS +: IW];
    endfunction

    function automatic logic oor_of(input logic [ADDR_W-1:0] a);
        return CHK && (|(a >> (OFS + IW)));
    endfunction

    logic              aw_held_q, aw_held_d, w_held_q, w_held_d, rdy_q;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [SW-1:0]     w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pulse_q, pulse_d;
    logic              aw_hs, w_hs, ar_hs, commit, w_oor;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [SW-1:0]     w_strb;
    logic [IW-1:0]     w_idx;
    logic              unused;

    // rdy_q keeps the READY outputs low until the first edge after reset release
    assign AwREADY  = rdy_q && !aw_held_q && !bvalid_q;
    assign WREADY   = rdy_q && !w_held_q && !bvalid_q;
    assign ARREADY  = rdy_q && !rvalid_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign wr_pulse = pulse_q;
    assign unused   = ^{AWPROT, ARPROT};

    assign aw_hs  = AWVALID && AwREADY;
    assign w_hs   = WVALID && WREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign w_addr = aw_held_q ? aw_addr_q : AWADDR;
    assign w_data = w_held_q ? w_data_q : WDATA;
    assign w_strb = w_held_q ? w_strb_q : WSTRB;
    assign w_idx  = idx_of(w_addr);
    assign w_oor  = oor_of(w_addr);

    for (genvar i = 0; i < DEPTH; i++) begin : g_out
        assign reg_out[i*DATA_W +: DATA_W] = regs_q[i];
    end

    always_comb begin
        aw_held_d = commit ? 1'b0 : aw_hs ? 1'b1 : aw_held_q;
        w_held_d  = commit ? 1'b0 : w_hs ? 1'b1 : w_held_q;
        aw_addr_d = aw_hs ? AWADDR : aw_addr_q;
        w_data_d  = w_hs ? WDATA : w_data_q;
        w_strb_d  = w_hs ? WSTRB : w_strb_q;
        bvalid_d  = commit || (bvalid_q && !BREADY);
        bresp_d   = commit ? (w_oor ? 2'b10 : 2'b00) : bresp_q;
        rvalid_d  = ar_hs || (rvalid_q && !RREADY);
        rresp_d   = ar_hs ? (oor_of(ARADDR) ? 2'b10 : 2'b00) : rresp_q;
        rdata_d   = ar_hs ? (oor_of(ARADDR) ? '0 : regs_q[idx_of(ARADDR)]) : rdata_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        if (commit && !w_oor) begin
            for (int k = 0; k < SW; k++)
                if (w_strb[k]) regs_d[w_idx][8*k +: 8] = w_data[8*k +: 8];
            pulse_d[w_idx] = |w_strb;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q     <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            rdy_q     <= 1'b1;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
            regs_q    <= regs_d;
        end
    end
endmodule

// File: tb/tb_axil_regfile.sv
// tb_axil_regfile: directed and randomized checks of axil_regfile (DATA_W 32, DEPTH 16) against an array model.
module tb_axil_regfile;
`ifdef AXIL_REGFILE_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk, rst;
    logic         AWVALID, AwREADY, WVALID, WREADY, BVALID, BREADY;
    logic         ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]  AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]   WSTRB;
    logic [2:0]   AWPROT, ARPROT;
    logic [1:0]   BRESP, RRESP;
    logic [511:0] reg_out;
    logic [15:0]  wr_pulse;

    int checks = 0;
    int failures = 0;
    logic [31:0] m [16];

    axil_regfile dut (
        .clk(clk), .rst(rst),
        .AWVALID(AWVALID), .AwREADY(AwREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic oor(input logic [31:0] a);
        return CHK && a >= 32'd64;
    endfunction

    function automatic void mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (oor(a)) return;
        for (int k = 0; k < 4; k++)
            if (s[k]) m[(a / 4) % 16][8*k +: 8] = d[8*k +: 8];
    endfunction

    function automatic logic [511:0] flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = m[i];
        return f;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, output logic [1:0] resp,
                            output logic [15:0] pulse, output int lat, output bit to);
        bit awd, wd;
        int c;
        awd = 0; wd = 0; c = 0;
        AWADDR = a; WDATA = d; WSTRB = s;
        while (!(awd && wd) && c < 50) begin
            AWVALID = !awd && c >= aw_dly;
            WVALID  = !wd && c >= w_dly;
            @(negedge clk);
            if (AWVALID && AwREADY) awd = 1;
            if (WVALID && WREADY) wd = 1;
            @(posedge clk); #1;
            c++;
        end
        AWVALID = 0; WVALID = 0;
        lat = 0;
        @(negedge clk);
        while (!BVALID && lat < 20) begin @(negedge clk); lat++; end
        to = !(awd && wd) || !BVALID;
        resp = BRESP; pulse = wr_pulse;
        BREADY = 1;
        @(posedge clk); #1;
        BREADY = 0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat, output bit to);
        bit done;
        int c;
        done = 0; c = 0;
        ARADDR = a; ARVALID = 1;
        while (!done && c < 20) begin
            @(negedge clk);
            done = ARREADY;
            @(posedge clk); #1;
            c++;
        end
        ARVALID = 0;
        lat = 0;
        @(negedge clk);
        while (!RVALID && lat < 20) begin @(negedge clk); lat++; end
        to = !done || !RVALID;
        d = RDATA; resp = RRESP;
        RREADY = 1;
        @(posedge clk); #1;
        RREADY = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({AwREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA} !== '0 || reg_out !== '0 || wr_pulse !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%h/%h exp=0", {AwREADY, WREADY, ARREADY, BVALID, RVALID}, reg_out, wr_pulse);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({AwREADY, WREADY, ARREADY} !== 3'b000) begin
            failures++; $display("FAIL reset_ready_async got=%b exp=000", {AwREADY, WREADY, ARREADY});
        end
        @(negedge clk);
        checks++;
        if ({AwREADY, WREADY, ARREADY} !== 3'b111) begin
            failures++; $display("FAIL reset_ready_rise got=%b exp=111", {AwREADY, WREADY, ARREADY});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [1:0] r; logic [15:0] p; logic [31:0] d; int lat; bit to;
        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, r, p, lat, to);
        mwrite(32'h4, 32'hDEADBEEF, 4'hF);
        checks++;
        if (to || lat != 0 || r !== 2'b00) begin
            failures++; $display("FAIL basic_bresp got=to%0d lat%0d resp%b exp=to0 lat0 resp00", to, lat, r);
        end
        checks++;
        if (p !== 16'h0002) begin failures++; $display("FAIL basic_pulse got=%h exp=0002", p); end
        checks++;
        if (reg_out !== flat()) begin failures++; $display("FAIL basic_regout got=%h exp=%h", reg_out, flat()); end
        do_read(32'h4, d, r, lat, to);
        checks++;
        if (to || lat != 0 || d !== 32'hDEADBEEF || r !== 2'b00) begin
            failures++; $display("FAIL basic_read got=%h resp%b lat%0d exp=deadbeef resp00 lat0", d, r, lat);
        end
    endtask

    task automatic test_w_first();
        logic [1:0] r; logic [15:0] p; logic [31:0] d; int lat; bit to;
        do_write(32'h8, 32'h11223344, 4'h5, 3, 0, r, p, lat, to);
        mwrite(32'h8, 32'h11223344, 4'h5);
        checks++;
        if (to || lat != 0 || r !== 2'b00 || p !== 16'h0004) begin
            failures++; $display("FAIL wfirst_resp got=to%0d lat%0d resp%b pulse%h exp=to0 lat0 resp00 pulse0004", to, lat, r, p);
        end
        do_read(32'h8, d, r, lat, to);
        checks++;
        if (to || d !== 32'h00220044 || r !== 2'b00) begin
            failures++; $display("FAIL wfirst_read got=%h exp=00220044", d);
        end
    endtask

    task automatic test_bready_stall();
        logic [31:0] v;
        v = $urandom;
        AWADDR = 32'hC; WDATA = v; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        @(negedge clk);
        checks++;
        if ({AwREADY, WREADY} !== 2'b11) begin failures++; $display("FAIL stall_accept got=%b exp=11", {AwREADY, WREADY}); end
        @(posedge clk); #1;
        AWVALID = 0; WVALID = 0;
        mwrite(32'hC, v, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({BVALID, AwREADY, WREADY} !== 3'b100) begin
                failures++; $display("FAIL stall_hold cycle=%0d got=%b exp=100", i, {BVALID, AwREADY, WREADY});
            end
            @(posedge clk); #1;
        end
        BREADY = 1;
        @(negedge clk);
        checks++;
        if (BVALID !== 1'b1) begin failures++; $display("FAIL stall_bvalid_before got=%b exp=1", BVALID); end
        @(posedge clk); #1;
        BREADY = 0;
        @(negedge clk);
        checks++;
        if ({BVALID, AwREADY, WREADY} !== 3'b011 || reg_out !== flat()) begin
            failures++; $display("FAIL stall_done got=%b exp=011", {BVALID, AwREADY, WREADY});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_same_edge();
        logic [1:0] r; logic [31:0] d, old; int lat; bit to;
        old = m[1];
        AWADDR = 32'h4; WDATA = 32'h0; WSTRB = 4'hF; ARADDR = 32'h4;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        @(negedge clk);
        checks++;
        if ({AwREADY, WREADY, ARREADY} !== 3'b111) begin
            failures++; $display("FAIL same_ready got=%b exp=111", {AwREADY, WREADY, ARREADY});
        end
        @(posedge clk); #1;
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        mwrite(32'h4, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (RVALID !== 1'b1 || BVALID !== 1'b1 || RDATA !== old) begin
            failures++; $display("FAIL same_rdata got=%h rv%b bv%b exp=%h rv1 bv1", RDATA, RVALID, BVALID, old);
        end
        BREADY = 1; RREADY = 1;
        @(posedge clk); #1;
        BREADY = 0; RREADY = 0;
        do_read(32'h4, d, r, lat, to);
        checks++;
        if (to || d !== m[1]) begin failures++; $display("FAIL same_next got=%h exp=%h", d, m[1]); end
    endtask

    task automatic test_addr_range();
        logic [1:0] r; logic [15:0] p; logic [31:0] d, v; int lat; bit to;
        v = $urandom | 32'h1;
        do_write(32'h100, v, 4'hF, 0, 0, r, p, lat, to);
        mwrite(32'h100, v, 4'hF);
        checks++;
        if (to || r !== (CHK ? 2'b10 : 2'b00) || p !== (CHK ? 16'h0 : 16'h1)) begin
            failures++; $display("FAIL range_write got=resp%b pulse%h exp=resp%b", r, p, CHK ? 2'b10 : 2'b00);
        end
        checks++;
        if (reg_out !== flat()) begin failures++; $display("FAIL range_regs got=%h exp=%h", reg_out, flat()); end
        do_read(32'h100, d, r, lat, to);
        checks++;
        if (to || d !== (CHK ? 32'h0 : m[0]) || r !== (CHK ? 2'b10 : 2'b00)) begin
            failures++; $display("FAIL range_read got=%h resp%b", d, r);
        end
    endtask

    task automatic test_random();
        logic [1:0] r, er; logic [15:0] p, ep; logic [31:0] a, d, v; logic [3:0] s; int lat; bit to;
        for (int n = 0; n < 60; n++) begin
            a = $urandom_range(0, 127);
            if ($urandom_range(0, 2) != 0) begin
                v = $urandom; s = 4'($urandom_range(0, 15));
                do_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), r, p, lat, to);
                er = oor(a) ? 2'b10 : 2'b00;
                ep = (!oor(a) && s != 0) ? (16'h1 << ((a / 4) % 16)) : 16'h0;
                mwrite(a, v, s);
                checks++;
                if (to || lat != 0 || r !== er || p !== ep) begin
                    failures++; $display("FAIL rand_write a=%h got=resp%b pulse%h lat%0d exp=resp%b pulse%h", a, r, p, lat, er, ep);
                end
                checks++;
                if (reg_out !== flat()) begin failures++; $display("FAIL rand_regs a=%h got=%h exp=%h", a, reg_out, flat()); end
            end else begin
                do_read(a, d, r, lat, to);
                checks++;
                if (to || lat != 0 || d !== (oor(a) ? 32'h0 : m[(a / 4) % 16]) || r !== (oor(a) ? 2'b10 : 2'b00)) begin
                    failures++; $display("FAIL rand_read a=%h got=%h resp%b exp=%h", a, d, r, oor(a) ? 32'h0 : m[(a / 4) % 16]);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic [1:0] r; logic [31:0] d; int lat; bit to;
        for (int i = 0; i < 16; i++) mwrite(i * 4, 32'hA5A50000 | i, 4'hF);
        for (int i = 0; i < 16; i++) begin
            do_write(i * 4, m[i], 4'hF, 0, 0, r, d[15:0], lat, to);
        end
        AWADDR = 32'h10; WDATA = $urandom; WSTRB = 4'hF; ARADDR = 32'h4;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        @(negedge clk);
        @(posedge clk); #1;
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        @(negedge clk);
        checks++;
        if ({RVALID, BVALID} !== 2'b11) begin failures++; $display("FAIL inflight_pre got=%b exp=11", {RVALID, BVALID}); end
        #2 rst = 0;
        #1;
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        checks++;
        if ({RVALID, BVALID, ARREADY, AwREADY} !== 4'b0000 || reg_out !== flat() || wr_pulse !== 16'h0) begin
            failures++; $display("FAIL inflight_reset got=%b regs=%h exp=0000 regs=0", {RVALID, BVALID, ARREADY, AwREADY}, reg_out);
        end
        @(negedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if (ARREADY !== 1'b0) begin failures++; $display("FAIL inflight_arready_early got=%b exp=0", ARREADY); end
        @(posedge clk); #1;
        checks++;
        if ({ARREADY, AwREADY, WREADY} !== 3'b111) begin
            failures++; $display("FAIL inflight_arready got=%b exp=111", {ARREADY, AwREADY, WREADY});
        end
        do_read(32'h4, d, r, lat, to);
        checks++;
        if (to || d !== 32'h0 || r !== 2'b00) begin failures++; $display("FAIL inflight_read got=%h exp=0", d); end
    endtask

    initial begin
        rst = 0;
        {AWVALID, WVALID, BREADY, ARVALID, RREADY} = '0;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0; AWPROT = '0; ARPROT = '0;
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        test_reset();
        test_basic();
        test_w_first();
        test_bready_stall();
        test_same_edge();
        test_addr_range();
        test_random();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
